trace_packet_framer: RTL and testbench

Downstream stage of the trace-system 2:1 packet mux. It consumes the mux's channel-tagged 8-bit Avalon-ST packet stream. Each packet is wrapped with a header byte (channel + sequence number) and a trailer byte (error flag + payload length) before it goes to the capture FIFO. Malformed framing is repaired or dropped and counted, so the capture side always sees well-formed packets.

---
 rtl/trace_framer_pkg.sv | 41 ++++
 rtl/trace_framer_out_reg.sv | 62 ++++++
 rtl/trace_packet_framer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_trace_packet_framer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_framer_pkg.sv
// -----------------------------------------------------------------------------
// trace_framer_pkg
// Shared definitions for the trace packet framer:
//   - FSM state encoding
//   - header layout: channel in the MSBs, sequence number in the LSBs
//   - trailer layout: error flag in bit 7, saturating payload length in [6:0]
// Optional feature macro: TRACE_FRAMER_TIMESTAMP_EN adds the ST_TSTAMP state.
// -----------------------------------------------------------------------------
package trace_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
`ifdef TRACE_FRAMER_TIMESTAMP_EN
        ST_TSTAMP  = 3'd4,
`endif
        ST_TRAILER = 3'd3
    } framer_state_t;

    // Header byte is {chan, seq}: the channel takes the top bits and the
    // sequence number fills whatever is left of the byte.
    localparam int HDR_BITS = 8;

    function automatic int seq_width_f(input int chan_width);
        return HDR_BITS - chan_width;
    endfunction

    // Trailer byte is {err, len[6:0]}.
    localparam int         TRL_ERR_BIT = 7;
    localparam logic [6:0] LEN_MASK    = 7'h7F;
    localparam logic [6:0] LEN_SAT     = 7'd127;

    function automatic logic [7:0] make_trailer(input logic err, input logic [6:0] len);
        logic [7:0] trl;
        trl                  = {1'b0, len & LEN_MASK};
        trl[TRL_ERR_BIT]     = err;
        return trl;
    endfunction

endpackage

// File: rtl/trace_framer_out_reg.sv
// -----------------------------------------------------------------------------
// trace_framer_out_reg
// One-slot registered output stage of the trace packet framer.
// A new beat may be written whenever the slot is empty or being accepted
// (load_en). When load_en is high and no beat is offered, the slot empties.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load                  a beat is offered this cycle (honoured only when load_en)
//   load_data/sop/eop     payload of the offered beat
//   out_ready             downstream ready
//   load_en               slot can take a new beat this cycle
//   out_valid/data/sop/eop registered output beat
// -----------------------------------------------------------------------------
module trace_framer_out_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_sop,
    input  logic       load_eop,
    input  logic       out_ready,
    output logic       load_en,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_startofpacket,
    output logic       out_endofpacket
);

    logic       valid_r;
    logic [7:0] data_r;
    logic       sop_r;
    logic       eop_r;

    assign load_en = !valid_r || out_ready;

    // Output slot: load a new beat, drain on accept, otherwise hold steady.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
            data_r  <= 8'h00;
            sop_r   <= 1'b0;
            eop_r   <= 1'b0;
        end else if (load_en) begin
            if (load) begin
                valid_r <= 1'b1;
                data_r  <= load_data;
                sop_r   <= load_sop;
                eop_r   <= load_eop;
            end else begin
                valid_r <= 1'b0;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid         = valid_r;
    assign out_data          = data_r;
    assign out_startofpacket = sop_r;
    assign out_endofpacket   = eop_r;

endmodule

// File: rtl/trace_packet_framer.sv
// -----------------------------------------------------------------------------
// trace_packet_framer
// Wraps each channel-tagged Avalon-ST packet with a header byte {chan, seq}
// and a trailer byte {err, len}. Beats outside a packet are dropped; a packet
// cut short by a new sop is closed with err=1. Both events bump drop_count.
// Optional feature macro: TRACE_FRAMER_TIMESTAMP_EN -- inserts a timestamp
// beat (8-bit free-running cycle count sampled at sop) after the header.
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_channel  upstream beat
//   in_startofpacket/in_endofpacket       upstream framing
//   out_valid/out_ready/out_data          framed downstream beat
//   out_startofpacket/out_endofpacket     header / trailer markers
//   drop_count                            saturating drop + repair count
// -----------------------------------------------------------------------------
module trace_packet_framer
    import trace_framer_pkg::*;
#(
    parameter int CHANNEL_WIDTH  = 1,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_data,
    input  logic [CHANNEL_WIDTH-1:0]  in_channel,
    input  logic                      in_startofpacket,
    input  logic                      in_endofpacket,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_data,
    output logic                      out_startofpacket,
    output logic                      out_endofpacket,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int SEQ_WIDTH = seq_width_f(CHANNEL_WIDTH);

    framer_state_t             state_r;
    framer_state_t             state_n;
    logic [CHANNEL_WIDTH-1:0]  chan_r;
    logic [SEQ_WIDTH-1:0]      seq_r;
    logic [6:0]                len_r;
    logic                      err_r;
    logic [DROP_CNT_WIDTH-1:0] drop_r;

    logic       load_en_s;
    logic       load_s;
    logic [7:0] load_data_s;
    logic       load_sop_s;
    logic       load_eop_s;
    logic       in_ready_s;
    logic       consume_s;
    logic       repair_s;
    logic       drop_s;
    logic       start_s;

`ifdef TRACE_FRAMER_TIMESTAMP_EN
    logic [7:0] cycle_cnt_r;
    logic [7:0] tstamp_r;
`endif

    // A sop seen once the packet already has payload means the previous
    // packet lost its eop; len is only zero before the first payload beat.
    logic early_sop_s;
    assign early_sop_s = in_startofpacket && (len_r != 7'd0);

    assign start_s = (state_r == ST_IDLE) && in_valid && in_startofpacket;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_startofpacket) begin
                    state_n = ST_HEADER;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (load_en_s) begin
`ifdef TRACE_FRAMER_TIMESTAMP_EN
                    state_n = ST_TSTAMP;
`else
                    state_n = ST_PAYLOAD;
`endif
                end else begin
                    state_n = ST_HEADER;
                end
            end
`ifdef TRACE_FRAMER_TIMESTAMP_EN
            ST_TSTAMP: begin
                if (load_en_s) begin
                    state_n = ST_PAYLOAD;
                end else begin
                    state_n = ST_TSTAMP;
                end
            end
`endif
            ST_PAYLOAD: begin
                if (repair_s || (consume_s && in_endofpacket)) begin
                    state_n = ST_TRAILER;
                end else begin
                    state_n = ST_PAYLOAD;
                end
            end
            ST_TRAILER: begin
                if (load_en_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_TRAILER;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: what to load into the output slot and handshake strobes.
    always_comb begin
        load_s      = 1'b0;
        load_data_s = 8'h00;
        load_sop_s  = 1'b0;
        load_eop_s  = 1'b0;
        in_ready_s  = 1'b0;
        consume_s   = 1'b0;
        repair_s    = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // The sop beat is left on the bus and consumed in PAYLOAD.
                in_ready_s = !in_startofpacket;
                drop_s     = in_valid && !in_startofpacket;
            end
            ST_HEADER: begin
                load_s      = load_en_s;
                load_data_s = {chan_r, seq_r};
                load_sop_s  = 1'b1;
            end
`ifdef TRACE_FRAMER_TIMESTAMP_EN
            ST_TSTAMP: begin
                load_s      = load_en_s;
                load_data_s = tstamp_r;
            end
`endif
            ST_PAYLOAD: begin
                if (early_sop_s) begin
                    // Hold the new packet's sop beat until this one is closed.
                    in_ready_s = 1'b0;
                    repair_s   = load_en_s && in_valid;
                end else begin
                    in_ready_s  = load_en_s;
                    consume_s   = load_en_s && in_valid;
                    load_s      = consume_s;
                    load_data_s = in_data;
                end
            end
            ST_TRAILER: begin
                load_s      = load_en_s;
                load_data_s = make_trailer(err_r, len_r);
                load_eop_s  = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    assign in_ready = in_ready_s;

    // Channel is latched at sop; later channel changes inside the packet are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_r <= '0;
        end else if (start_s) begin
            chan_r <= in_channel;
        end else begin
            chan_r <= chan_r;
        end
    end

    // Sequence number advances as each trailer leaves; wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_r <= '0;
        end else if ((state_r == ST_TRAILER) && load_en_s) begin
            seq_r <= seq_r + SEQ_WIDTH'(1);
        end else begin
            seq_r <= seq_r;
        end
    end

    // Payload length (saturating) and error flag for the trailer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_r <= 7'd0;
            err_r <= 1'b0;
        end else if ((state_r == ST_HEADER) && load_en_s) begin
            len_r <= 7'd0;
            err_r <= 1'b0;
        end else if (repair_s) begin
            err_r <= 1'b1;
        end else if (consume_s && (len_r != LEN_SAT)) begin
            len_r <= len_r + 7'd1;
        end else begin
            len_r <= len_r;
        end
    end

    // Saturating counter of dropped stray beats and repaired packets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_r <= '0;
        end else if ((drop_s || repair_s) && (drop_r != {DROP_CNT_WIDTH{1'b1}})) begin
            drop_r <= drop_r + DROP_CNT_WIDTH'(1);
        end else begin
            drop_r <= drop_r;
        end
    end

    assign drop_count = drop_r;

`ifdef TRACE_FRAMER_TIMESTAMP_EN
    // Free-running cycle counter and its snapshot taken when a packet starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_r <= 8'h00;
            tstamp_r    <= 8'h00;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 8'd1;
            if (start_s) begin
                tstamp_r <= cycle_cnt_r;
            end else begin
                tstamp_r <= tstamp_r;
            end
        end
    end
`endif

    trace_framer_out_reg u_out_reg (
        .clk               (clk),
        .reset_n           (reset_n),
        .load              (load_s),
        .load_data         (load_data_s),
        .load_sop          (load_sop_s),
        .load_eop          (load_eop_s),
        .out_ready         (out_ready),
        .load_en           (load_en_s),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

endmodule

// File: tb/tb_trace_packet_framer.sv
// -----------------------------------------------------------------------------
// tb_trace_packet_framer
// Scoreboard bench for trace_packet_framer (CHANNEL_WIDTH=1, default build).
// Expected framed beats {sop, eop, data} are queued as stimulus is issued and
// popped when the DUT hands a beat downstream.
// -----------------------------------------------------------------------------
module tb_trace_packet_framer;

    localparam int CW = 1;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic [CW-1:0] in_channel = '0;
    logic          in_startofpacket = 1'b0;
    logic          in_endofpacket = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    out_data;
    logic          out_startofpacket;
    logic          out_endofpacket;
    logic [DW-1:0] drop_count;

    trace_packet_framer #(
        .CHANNEL_WIDTH  (CW),
        .DROP_CNT_WIDTH (DW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_channel        (in_channel),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] sb[$];
    logic [7:0] pkt[$];
    logic [6:0] seq_m = 7'd0;
    int         drop_m = 0;
    logic       tog_en = 1'b0;
    logic       rst_evt = 1'b0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat = 10'h000;
    logic [9:0] exp_beat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference framing of one packet held in pkt[]: header, payload, trailer.
    task automatic expect_packet(input logic ch, input logic err);
        int n;
        n = pkt.size();
        sb.push_back({2'b10, ch, seq_m});
        foreach (pkt[i]) sb.push_back({2'b00, pkt[i]});
        sb.push_back({2'b01, err, (n > 127) ? 7'd127 : 7'(n)});
        seq_m = seq_m + 7'd1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic ch, input logic s, input logic e);
        logic done;
        done = 1'b0;
        @(negedge clk);
        in_valid         = 1'b1;
        in_data          = d;
        in_channel       = ch;
        in_startofpacket = s;
        in_endofpacket   = e;
        for (int i = 0; i < 400 && !done; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check_eq("accept_wait", done, 1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        in_endofpacket   = 1'b0;
    endtask

    // Sends pkt[] as one packet; eop on the last beat only if with_eop.
    task automatic send_packet(input logic ch, input logic with_eop);
        int n;
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            send_beat(pkt[i], ch, i == 0, with_eop && (i == n - 1));
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        check_eq("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Downstream monitor: scoreboard compare on accept, hold check on stall.
    always @(negedge clk) begin
        #2;
        if (prev_stall && !rst_evt) begin
            check_eq("stall_hold", {out_valid, out_startofpacket, out_endofpacket, out_data},
                     {1'b1, prev_beat});
        end
        if (out_valid && out_ready) begin
            check_eq("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_beat = sb.pop_front();
                check_eq("out_beat", {out_startofpacket, out_endofpacket, out_data}, exp_beat);
            end
        end
        prev_stall = reset_n && out_valid && !out_ready;
        prev_beat  = {out_startofpacket, out_endofpacket, out_data};
    end

    // Downstream backpressure pattern: toggle ready every cycle when enabled.
    always @(negedge clk) begin
        if (tog_en) out_ready = ~out_ready;
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_drop", drop_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check_eq("idle_in_ready", in_ready, 1);

        // 1: channel 1, three bytes, then a second packet on channel 1.
        pkt = '{8'hA1, 8'hA2, 8'hA3};
        expect_packet(1'b1, 1'b0);
        send_packet(1'b1, 1'b1);
        pkt = '{8'h7E};
        expect_packet(1'b1, 1'b0);
        send_packet(1'b1, 1'b1);
        go_idle();
        wait_drain();

        // 2: single-beat packet on channel 0.
        pkt = '{8'h5C};
        expect_packet(1'b0, 1'b0);
        send_packet(1'b0, 1'b1);
        go_idle();
        wait_drain();

        // 3: two stray beats in IDLE, then a normal packet.
        send_beat(8'hAA, 1'b0, 1'b0, 1'b0);
        send_beat(8'hBB, 1'b1, 1'b0, 1'b1);
        drop_m += 2;
        pkt = '{8'h11, 8'h22};
        expect_packet(1'b0, 1'b0);
        send_packet(1'b0, 1'b1);
        go_idle();
        wait_drain();
        check_eq("drop_stray", drop_count, drop_m);

        // 4: packet missing eop, closed by the next sop, which is framed afterwards.
        pkt = '{8'h11, 8'h22};
        expect_packet(1'b0, 1'b1);
        send_packet(1'b0, 1'b0);
        drop_m += 1;
        pkt = '{8'h33};
        expect_packet(1'b1, 1'b0);
        send_packet(1'b1, 1'b1);
        go_idle();
        wait_drain();
        check_eq("drop_repair", drop_count, drop_m);

        // 5: 200-byte packet under alternating backpressure, length saturates.
        pkt.delete();
        for (int i = 0; i < 200; i++) pkt.push_back(8'(i) ^ 8'h5A);
        expect_packet(1'b0, 1'b0);
        tog_en = 1'b1;
        send_packet(1'b0, 1'b1);
        go_idle();
        wait_drain();
        tog_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // 6: reset in the middle of a packet with a stalled output beat.
        sb.push_back({2'b10, 1'b0, seq_m});
        sb.push_back({2'b00, 8'h10});
        sb.push_back({2'b00, 8'h20});
        send_beat(8'h10, 1'b0, 1'b1, 1'b0);
        send_beat(8'h20, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid         = 1'b0;
        in_startofpacket = 1'b0;
        out_ready        = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("pre_rst_valid", out_valid, 1);
        check_eq("pre_rst_drop", drop_count, drop_m);
        rst_evt = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_drop", drop_count, 0);
        sb.delete();
        seq_m  = 7'd0;
        drop_m = 0;
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst_evt = 1'b0;
        pkt = '{8'h44, 8'h45};
        expect_packet(1'b1, 1'b0);
        send_packet(1'b1, 1'b1);
        go_idle();
        wait_drain();
        check_eq("post_rst_drop", drop_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
